cdt_sampler_ctrl: RTL and testbench
===================================

Name: cdt_sampler_ctrl

Overview:
- Drives the Gaussian table ROM (grom_x) read port and turns one 32-bit uniform random word plus a sign bit into one signed discrete-Gaussian sample.
- Uses a constant-time, full-table cumulative-distribution (CDT) scan: every entry is read on every sample, whatever the random input, so timing does not leak the sample.
- Sits directly upstream of the ROM: it drives ADDR, CNTRL and Enable, and consumes read_data and status.

Parameters:
- TABLE_LEN, 16, number of CDT entries scanned; must be at least 2.
- BASE_ADDR, 32'd0, ROM word address of entry 0.
- ADDR_STRIDE, 32'd1, address increment between entries.
- SAMPLE_W, 8, width of the signed sample; must satisfy 2^(SAMPLE_W-1) > TABLE_LEN-1.
- TIMEOUT, 8, maximum WAIT cycles per read before an error is flagged.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request one sample; accepted only in IDLE.
- rnd, input, 32, uniform random word; latched on accept.
- rnd_sign, input, 1, sign bit (1 = negative); latched on accept.
- rom_addr, output, 32, ROM address; drives grom_x ADDR.
- rom_cntrl, output, 2, ROM command: 01 = read, 00 = idle, 10 (write) is never driven; drives grom_x CNTRL.
- rom_enable, output, 1, drives grom_x Enable.
- rom_rdata, input, 32, grom_x read_data.
- rom_status, input, 1, grom_x status; 1 means rom_rdata holds valid read data.
- busy, output, 1, high from accept until DONE/ERR exits to IDLE.
- sample, output, SAMPLE_W, signed two's-complement result; held until the next valid.
- valid, output, 1, one-cycle pulse marking a new sample.
- err, output, 1, sticky ROM-timeout flag; cleared on the next accepted start.

Behaviour:
- Reset (async assert, sync release): state=IDLE; rom_addr=0, rom_cntrl=00, rom_enable=0; busy=0, valid=0, err=0, sample=0; index and count=0.
- Reset mid-scan aborts immediately and produces no valid.
- States:
  - IDLE: if start=1, latch rnd and rnd_sign, index=0, count=0, err=0 -> ISSUE. Otherwise stay.
  - ISSUE (1 cycle): rom_addr = BASE_ADDR + index*ADDR_STRIDE; rom_cntrl=01; rom_enable=1 -> WAIT.
  - WAIT: rom_cntrl=00; rom_enable=1; rom_addr held.
    - If rom_status=1: count += (rom_rdata <= rnd_latched), unsigned compare. Then if index == TABLE_LEN-1 -> DONE, else index++ -> ISSUE.
    - If TIMEOUT cycles pass with rom_status=0 -> ERR.
    - rom_status is ignored outside WAIT.
  - DONE (1 cycle):
    - k = min(count, TABLE_LEN-1).
    - sample = rnd_sign ? -k : +k; k=0 always gives 0 (never -0).
    - valid=1 -> IDLE.
  - ERR (1 cycle): err=1, no valid, sample unchanged -> IDLE.
- busy=1 in ISSUE, WAIT, DONE and ERR.
- rom_enable=0 and rom_cntrl=00 in IDLE, DONE and ERR.
- Latency with rom_status returning 1 on the first WAIT cycle: valid asserts 2*TABLE_LEN+1 cycles after the start-accept edge. Every sample takes the same time regardless of rnd.
- start while busy is ignored and not queued. start held high in IDLE re-triggers on the cycle after DONE returns to IDLE.
- count is at least clog2(TABLE_LEN+1) bits wide and cannot overflow.
- rnd=32'hFFFFFFFF with every entry <= rnd gives count=TABLE_LEN, saturated to TABLE_LEN-1.
- rnd, rnd_sign and rom_rdata are not sampled outside the states listed.

Test Plan:
1. ROM model loaded with entry i = 100*(i+1) (100..1600), status returned one cycle after read. start with rnd=250, rnd_sign=0 -> addresses 0..15 each issued once with CNTRL=01 then 00; valid pulses exactly 33 cycles after accept; sample=8'sd2.
2. rnd=50, rnd_sign=1 -> sample=0 (not negative zero), valid at the same 33-cycle point.
3. rnd=32'hFFFFFFFF, rnd_sign=1 -> count=16 saturated to 15; sample=8'hF1 (-15).
4. ROM model holds status=0 at address 5 -> err=1 after 8 WAIT cycles; no valid; busy drops the next cycle. A following start with a normal ROM clears err and sample=2 for rnd=250.
5. Pulse start again at cycle 10 of a scan -> ignored: exactly one valid and rnd not relatched. Assert rst_n=0 at cycle 20 -> outputs go to reset values immediately; no valid follows.
6. BASE_ADDR=324, ADDR_STRIDE=4 -> addresses issued are 324, 328, ..., 384; result for rnd=250 unchanged (sample=2).

Source files
------------

// File: rtl/cdt_sampler_ctrl.sv
// rtl/cdt_sampler_ctrl.sv - constant-time CDT discrete-Gaussian sampler driving the grom_x read port
module cdt_sampler_ctrl #(
    parameter int unsigned TABLE_LEN   = 16,
    parameter logic [31:0] BASE_ADDR   = 32'd0,
    parameter logic [31:0] ADDR_STRIDE = 32'd1,
    parameter int unsigned SAMPLE_W    = 8,
    parameter int unsigned TIMEOUT     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [31:0]         rnd,
    input  logic                rnd_sign,
    output logic [31:0]         rom_addr,
    output logic [1:0]          rom_cntrl,
    output logic                rom_enable,
    input  logic [31:0]         rom_rdata,
    input  logic                rom_status,
    output logic                busy,
    output logic [SAMPLE_W-1:0] sample,
    output logic                valid,
    output logic                err
);

    localparam int unsigned IDX_W = $clog2(TABLE_LEN);
    localparam int unsigned CNT_W = $clog2(TABLE_LEN + 1);
    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TABLE_LEN - 1);
    localparam logic [CNT_W-1:0] K_MAX    = CNT_W'(TABLE_LEN - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    localparam logic [1:0] CMD_IDLE = 2'b00;
    localparam logic [1:0] CMD_READ = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         rnd_q, rnd_d;
    logic                sign_q, sign_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [31:0]         addr_q, addr_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;

    // Clamped magnitude: a word above every entry counts TABLE_LEN, saturated to the last index.
    logic [CNT_W-1:0]    k_mag;
    logic [SAMPLE_W-1:0] k_ext;

    assign k_mag = (cnt_q > K_MAX) ? K_MAX : cnt_q;
    assign k_ext = SAMPLE_W'(k_mag);

    // State and datapath registers; reset aborts any scan in flight without a valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rnd_q    <= '0;
            sign_q   <= 1'b0;
            idx_q    <= '0;
            cnt_q    <= '0;
            tmo_q    <= '0;
            addr_q   <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rnd_q    <= rnd_d;
            sign_q   <= sign_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            addr_q   <= addr_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    // Next-state and ROM command decode; every entry is visited regardless of rnd.
    always_comb begin
        state_d    = state_q;
        rnd_d      = rnd_q;
        sign_d     = sign_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        addr_d     = addr_q;
        sample_d   = sample_q;
        valid_d    = 1'b0;
        err_d      = err_q;
        rom_cntrl  = CMD_IDLE;
        rom_enable = 1'b0;
        busy       = 1'b1;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    rnd_d   = rnd;
                    sign_d  = rnd_sign;
                    idx_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    addr_d  = BASE_ADDR;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                rom_cntrl  = CMD_READ;
                rom_enable = 1'b1;
                tmo_d      = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                rom_enable = 1'b1;
                if (rom_status) begin
                    if (rom_rdata <= rnd_q) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        addr_d  = addr_q + ADDR_STRIDE;
                        state_d = S_ISSUE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_DONE: begin
                // Two's-complement negate of zero is zero, so no negative zero can appear.
                sample_d = sign_q ? (~k_ext + SAMPLE_W'(1)) : k_ext;
                valid_d  = 1'b1;
                state_d  = S_IDLE;
            end
            S_ERR: begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rom_addr = addr_q;
    assign sample   = sample_q;
    assign valid    = valid_q;
    assign err      = err_q;

endmodule

// File: tb/tb_cdt_sampler_ctrl.sv
// tb/tb_cdt_sampler_ctrl.sv - scoreboard bench for cdt_sampler_ctrl
module tb_cdt_sampler_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start      [2];
    logic [31:0] rnd_v      [2];
    logic        sgn        [2];
    logic [31:0] rom_addr   [2];
    logic [1:0]  rom_cntrl  [2];
    logic        rom_enable [2];
    logic [31:0] rom_rdata  [2];
    logic        rom_status [2];
    logic        busy       [2];
    logic [7:0]  sample     [2];
    logic        valid      [2];
    logic        err        [2];

    typedef struct {
        int         dut;
        logic [7:0] smp;
    } exp_t;

    exp_t        exp_q[$];
    int          nvec = 0;
    int          nfail = 0;
    int          cyc = 0;
    int          acc  [2];
    int          rd_n [2];
    logic [31:0] stall_addr = 32'hFFFF_FFFF;

    localparam int LAT = 33;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam logic [31:0] BASE = (g == 0) ? 32'd0 : 32'd324;
        localparam logic [31:0] STR  = (g == 0) ? 32'd1 : 32'd4;

        cdt_sampler_ctrl #(
            .TABLE_LEN  (16),
            .BASE_ADDR  (BASE),
            .ADDR_STRIDE(STR),
            .SAMPLE_W   (8),
            .TIMEOUT    (8)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start[g]),
            .rnd       (rnd_v[g]),
            .rnd_sign  (sgn[g]),
            .rom_addr  (rom_addr[g]),
            .rom_cntrl (rom_cntrl[g]),
            .rom_enable(rom_enable[g]),
            .rom_rdata (rom_rdata[g]),
            .rom_status(rom_status[g]),
            .busy      (busy[g]),
            .sample    (sample[g]),
            .valid     (valid[g]),
            .err       (err[g])
        );

        // ROM model: entry i holds 100*(i+1); status answers one cycle after a read unless stalled.
        always @(posedge clk) begin
            int unsigned idx;
            rom_status[g] <= 1'b0;
            if (rom_enable[g] && rom_cntrl[g] == 2'b01) begin
                idx = (rom_addr[g] - BASE) / STR;
                rom_rdata[g] <= 32'(100 * (idx + 1));
                if (rom_addr[g] != stall_addr) rom_status[g] <= 1'b1;
            end
        end

        // Monitor: tracks accepts and read addresses, pops the scoreboard on each valid.
        always @(negedge clk) begin
            exp_t e;
            if (rst_n && start[g] && !busy[g]) begin
                acc[g]  = cyc + 1;
                rd_n[g] = 0;
            end
            if (rom_enable[g] && rom_cntrl[g] == 2'b01) begin
                chk("rom_addr", rom_addr[g], BASE + 32'(rd_n[g]) * STR);
                rd_n[g]++;
            end
            if (valid[g]) begin
                if (exp_q.size() == 0) begin
                    nvec++;
                    nfail++;
                    $display("FAIL unexpected_valid: dut %0d sample %0h with nothing expected", g, sample[g]);
                end else begin
                    e = exp_q.pop_front();
                    chk("valid_dut", 32'(g), 32'(e.dut));
                    chk("sample", 32'(sample[g]), 32'(e.smp));
                    chk("latency", 32'(cyc - acc[g]), 32'(LAT));
                    chk("reads_per_scan", 32'(rd_n[g]), 32'd16);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int g, input logic [31:0] r, input logic s, input logic [7:0] e, input bit want);
        exp_t x;
        tick();
        start[g] = 1'b1;
        rnd_v[g] = r;
        sgn[g]   = s;
        if (want) begin
            x.dut = g;
            x.smp = e;
            exp_q.push_back(x);
        end
        tick();
        start[g] = 1'b0;
        rnd_v[g] = '0;
        sgn[g]   = 1'b0;
        chk("busy_on_accept", 32'(busy[g]), 32'd1);
    endtask

    task automatic wait_idle(input int g);
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            tick();
            if (!busy[g] && exp_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            nvec++;
            nfail++;
            $display("FAIL wait_idle: dut %0d still busy=%0b pending=%0d, expected idle", g, busy[g], exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic chk_reset_vals(input int g);
        chk("rst_busy", 32'(busy[g]), 32'd0);
        chk("rst_valid", 32'(valid[g]), 32'd0);
        chk("rst_err", 32'(err[g]), 32'd0);
        chk("rst_sample", 32'(sample[g]), 32'd0);
        chk("rst_enable", 32'(rom_enable[g]), 32'd0);
        chk("rst_cntrl", 32'(rom_cntrl[g]), 32'd0);
        chk("rst_addr", rom_addr[g], 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        for (int g = 0; g < 2; g++) begin
            start[g] = 1'b0;
            rnd_v[g] = '0;
            sgn[g]   = 1'b0;
        end
        repeat (2) tick();
        chk_reset_vals(0);
        chk_reset_vals(1);
        rst_n = 1'b1;
        tick();

        // Table 100..1600: 250 covers two entries, 50 none, all-ones all sixteen.
        run(0, 32'd250, 1'b0, 8'd2, 1'b1);
        wait_idle(0);
        run(0, 32'd50, 1'b1, 8'd0, 1'b1);
        wait_idle(0);
        run(0, 32'hFFFF_FFFF, 1'b1, 8'hF1, 1'b1);
        wait_idle(0);

        // Stalled read at address 5: 8 WAIT cycles, one ERR cycle, then idle with err set.
        stall_addr = 32'd5;
        run(0, 32'd250, 1'b0, 8'd0, 1'b0);
        repeat (19) tick();
        chk("err_before_exit", 32'(err[0]), 32'd0);
        chk("busy_in_err", 32'(busy[0]), 32'd1);
        tick();
        chk("err_flag", 32'(err[0]), 32'd1);
        chk("busy_after_err", 32'(busy[0]), 32'd0);
        chk("sample_held", 32'(sample[0]), 32'hF1);
        stall_addr = 32'hFFFF_FFFF;
        repeat (3) tick();
        chk("err_sticky", 32'(err[0]), 32'd1);
        run(0, 32'd250, 1'b0, 8'd2, 1'b1);
        chk("err_cleared", 32'(err[0]), 32'd0);
        wait_idle(0);

        // Start pulse mid-scan with different operands must be ignored.
        run(0, 32'd250, 1'b0, 8'd2, 1'b1);
        repeat (9) tick();
        start[0] = 1'b1;
        rnd_v[0] = 32'd50;
        sgn[0]   = 1'b1;
        tick();
        start[0] = 1'b0;
        rnd_v[0] = '0;
        sgn[0]   = 1'b0;
        wait_idle(0);
        repeat (40) tick();

        // Reset mid-scan: immediate return to reset values and no valid afterwards.
        run(0, 32'd250, 1'b0, 8'd2, 1'b1);
        repeat (19) tick();
        rst_n = 1'b0;
        #1;
        chk_reset_vals(0);
        exp_q.delete();
        repeat (40) tick();
        rst_n = 1'b1;
        tick();

        // Offset and strided table placement.
        run(1, 32'd250, 1'b0, 8'd2, 1'b1);
        wait_idle(1);
        run(1, 32'd1000, 1'b1, 8'hF6, 1'b1);
        wait_idle(1);

        repeat (5) tick();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
